// File: rtl/oscilo_pkg.sv
// rtl/oscilo_pkg.sv - shared types and constants for the sample readout path
//
// Purpose: readout FSM state encoding, default header sync byte, RAM read
// latency and the depth of the readout byte FIFO.
// Ports: none (package).
package oscilo_pkg;

  typedef enum logic [1:0] {
    ST_RD_IDLE,
    ST_RD_HEADER,
    ST_RD_STREAM,
    ST_RD_DRAIN
  } rd_state_t;

  localparam logic [7:0] HDR_SYNC_DEFAULT   = 8'hA5;
  localparam int         MEM_READ_LATENCY   = 1;
  localparam int         READOUT_FIFO_DEPTH = 2;

endpackage

// File: rtl/fifo2.sv
// rtl/fifo2.sv - 2-entry first-word-fall-through byte FIFO
//
// Purpose: small elastic buffer between a fixed-latency source and a
// valid/ready consumer. Entry 0 is always the head.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-low reset
//   wr_en     in   push wr_data
//   wr_data   in   8-bit push data
//   rd_en     in   pop the head (ignored when empty)
//   rd_data   out  head byte
//   rd_valid  out  head is valid
//   count     out  occupancy 0..2
module fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [1:0] count
);

  logic [7:0] entry0;
  logic [7:0] entry1;
  logic       do_pop;
  logic       do_push;

  assign do_pop   = rd_en && (count != 2'd0);
  // A push into a full FIFO is only honoured when a pop frees a slot.
  assign do_push  = wr_en && ((count != 2'd2) || do_pop);
  assign rd_data  = entry0;
  assign rd_valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry0 <= 8'd0;
      entry1 <= 8'd0;
      count  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= wr_data;
          else               entry1 <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= wr_data;
          end else begin
            entry0 <= entry1;
            entry1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sample_readout.sv
// rtl/sample_readout.sv - linearising readout of the circular sample RAM
//
// Purpose: after a capture, reads 2^SAMPLE_DEPTH bytes from the sample RAM
// starting at the oldest sample (wrapping modulo depth) and streams them out
// on a valid/ready byte interface, oldest sample first.
// Optional feature macro: READOUT_HEADER_EN (prefixes HDR_SYNC, SAMPLE_DEPTH).
// Ports:
//   clk_50mhz   in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   activate    in   start a frame when high in IDLE
//   start_addr  in   oldest-sample address, latched on activate
//   done        out  frame complete, cleared by next accepted activate
//   busy        out  frame in progress
//   mem_addr    out  RAM read address
//   mem_re      out  RAM read strobe (data returns one cycle later)
//   mem_data    in   RAM read data
//   out_data    out  stream byte
//   out_valid   out  stream byte valid
//   out_ready   in   consumer ready
module sample_readout
  import oscilo_pkg::*;
#(
  parameter int SAMPLE_DEPTH = 8
`ifdef READOUT_HEADER_EN
  ,
  parameter logic [7:0] HDR_SYNC = HDR_SYNC_DEFAULT
`endif
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    activate,
  input  logic [SAMPLE_DEPTH-1:0] start_addr,
  output logic                    done,
  output logic                    busy,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_re,
  input  logic [7:0]              mem_data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int N  = 2 ** SAMPLE_DEPTH;
  localparam int CW = SAMPLE_DEPTH + 2;
`ifdef READOUT_HEADER_EN
  localparam int FRAME_LEN = N + 2;
`else
  localparam int FRAME_LEN = N;
`endif
  localparam logic [SAMPLE_DEPTH:0] LAST_ISSUE  = (SAMPLE_DEPTH + 1)'(N - 1);
  localparam logic [CW-1:0]         LAST_ACCEPT = CW'(FRAME_LEN - 1);

  rd_state_t                   state;
  rd_state_t                   state_nxt;
  logic [SAMPLE_DEPTH-1:0]     base_addr;
  logic [SAMPLE_DEPTH:0]       issued;
  logic [CW-1:0]               accepted;
  logic [MEM_READ_LATENCY-1:0] rd_pipe;
  logic [1:0]                  fifo_count;
  logic                        issue;
  logic                        start;
  logic                        push;
  logic [7:0]                  push_data;
  logic                        pop;
  int                          occupancy;
`ifdef READOUT_HEADER_EN
  logic                        hdr_idx;
  logic                        hdr_push;
`endif

  assign pop      = out_valid && out_ready;
  assign mem_re   = issue;
  assign mem_addr = issue ? (base_addr + issued[SAMPLE_DEPTH-1:0]) : '0;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start     = 1'b0;
    push      = rd_pipe[MEM_READ_LATENCY-1];
    push_data = mem_data;
`ifdef READOUT_HEADER_EN
    hdr_push  = 1'b0;
`endif
    // Slots already committed after this edge: stored bytes plus reads still
    // in flight, less the byte leaving now. Counting the pop keeps 1 byte/cycle.
    occupancy = int'(fifo_count) + $countones(rd_pipe) - int'(pop);
    case (state)
      ST_RD_IDLE: begin
        if (activate) begin
          start = 1'b1;
`ifdef READOUT_HEADER_EN
          state_nxt = ST_RD_HEADER;
`else
          state_nxt = ST_RD_STREAM;
`endif
        end
      end
      ST_RD_HEADER: begin
`ifdef READOUT_HEADER_EN
        // No reads are in flight here, so header bytes always enter the FIFO
        // ahead of any sample.
        if (occupancy < READOUT_FIFO_DEPTH) begin
          push      = 1'b1;
          hdr_push  = 1'b1;
          push_data = hdr_idx ? 8'(SAMPLE_DEPTH) : HDR_SYNC;
          if (hdr_idx) state_nxt = ST_RD_STREAM;
        end
`else
        state_nxt = ST_RD_IDLE;
`endif
      end
      ST_RD_STREAM: begin
        if (occupancy < READOUT_FIFO_DEPTH) begin
          issue = 1'b1;
          if (issued == LAST_ISSUE) state_nxt = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if (pop && (accepted == LAST_ACCEPT)) state_nxt = ST_RD_IDLE;
      end
      default: state_nxt = ST_RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      state     <= ST_RD_IDLE;
      base_addr <= '0;
      issued    <= '0;
      accepted  <= '0;
      rd_pipe   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_idx   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      rd_pipe <= MEM_READ_LATENCY'({rd_pipe, issue});
      if (start) begin
        base_addr <= start_addr;
        issued    <= '0;
        accepted  <= '0;
        done      <= 1'b0;
        busy      <= 1'b1;
`ifdef READOUT_HEADER_EN
        hdr_idx   <= 1'b0;
`endif
      end else begin
        if (issue) issued <= issued + 1'b1;
        if (pop)   accepted <= accepted + 1'b1;
`ifdef READOUT_HEADER_EN
        if (hdr_push) hdr_idx <= 1'b1;
`endif
        if ((state == ST_RD_DRAIN) && (state_nxt == ST_RD_IDLE)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  fifo2 u_fifo (
    .clk      (clk_50mhz),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (push_data),
    .rd_en    (pop),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_sample_readout.sv
// tb/tb_sample_readout.sv - directed self-checking bench for sample_readout
module tb_sample_readout;

`ifdef READOUT_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int FRAME     = 256 + HDR;
  localparam int FIRST_K   = (HDR != 0) ? 1 : 2;
  localparam int BUDGET    = 3000;

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       activate;
  logic [7:0] start_addr;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic [7:0] mem_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] ram [256];

  int errors = 0;
  int checks = 0;

  logic [7:0] got[$];
  logic [7:0] addrs[$];
  bit c_timeout;
  int c_stable_bad, c_outst_bad, c_first_valid, c_first_acc, c_last_acc, c_done_k;
  logic c_busy_at_done;

  sample_readout #(.SAMPLE_DEPTH(8)) dut (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .activate   (activate),
    .start_addr (start_addr),
    .done       (done),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_data   (mem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz) begin
    if (mem_re === 1'b1) mem_data <= ram[mem_addr];
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] a, input int i);
    if (i < HDR) return (i == 0) ? 8'hA5 : 8'h08;
    return a + 8'(i - HDR);
  endfunction

  function automatic int order_bad(input logic [7:0] a);
    int bad = 0;
    foreach (got[i]) if (got[i] !== exp_byte(a, i)) bad++;
    return bad;
  endfunction

  task automatic start_frame(input logic [7:0] a);
    start_addr = a;
    activate   = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk_50mhz);
    activate   = 1'b0;
  endtask

  // Observes the stream from a negedge; records bytes, read addresses and
  // protocol violations. Stops on done, on stop_after accepts, or on budget.
  task automatic collect(input int ready_pct, input int stop_after, input int pulse_at,
                         input int init_out, input int budget);
    int k = 0;
    int outst = init_out;
    bit pulsed = 0;
    bit pop_now;
    logic pv = 0, pr = 0;
    logic [7:0] pd = 0;
    got.delete(); addrs.delete();
    c_timeout = 0; c_stable_bad = 0; c_outst_bad = 0;
    c_first_valid = -1; c_first_acc = -1; c_last_acc = -1; c_done_k = -1;
    c_busy_at_done = 1'bx;
    forever begin
      out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      activate = 1'b0;
      if (!pulsed && pulse_at >= 0 && got.size() == pulse_at) begin
        activate = 1'b1;
        pulsed = 1;
      end
      #1;
      if (done === 1'b1) begin
        c_done_k = k;
        c_busy_at_done = busy;
        break;
      end
      if (k >= budget) begin
        c_timeout = 1;
        break;
      end
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) c_stable_bad++;
      pop_now = (out_valid === 1'b1) && (out_ready === 1'b1);
      if (out_valid === 1'b1 && c_first_valid < 0) c_first_valid = k;
      if (mem_re === 1'b1) begin
        if (outst - int'(pop_now) >= 2) c_outst_bad++;
        addrs.push_back(mem_addr);
        outst++;
      end
      if (pop_now) begin
        got.push_back(out_data);
        if (c_first_acc < 0) c_first_acc = k;
        c_last_acc = k;
        outst--;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      k++;
      if (stop_after > 0 && got.size() == stop_after) break;
      @(negedge clk_50mhz);
    end
    activate = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; activate = 1'b0; start_addr = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset mem_re: got %b want 0", mem_re); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset mem_addr: got %h want 00", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h want 00", out_data); end
    reset = 1'b1;
    @(negedge clk_50mhz);
  endtask

  task automatic test_linear;
    int bad;
    start_frame(8'h00);
    collect(100, 0, -1, HDR, BUDGET);
    bad = order_bad(8'h00);
    checks++; if (c_timeout !== 1'b0) begin errors++; $display("FAIL linear timeout: got %0d want 0", c_timeout); end
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL linear count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL linear order: got %0d mismatches want 0", bad); end
    checks++; if (c_first_valid !== FIRST_K) begin errors++; $display("FAIL linear first_valid: got %0d want %0d", c_first_valid, FIRST_K); end
`ifndef READOUT_HEADER_EN
    checks++; if (c_last_acc - c_first_acc !== 255) begin errors++; $display("FAIL linear span: got %0d want 255", c_last_acc - c_first_acc); end
`endif
    checks++; if (c_done_k !== c_last_acc + 1) begin errors++; $display("FAIL linear done_time: got %0d want %0d", c_done_k, c_last_acc + 1); end
    checks++; if (c_busy_at_done !== 1'b0) begin errors++; $display("FAIL linear busy_at_done: got %b want 0", c_busy_at_done); end
    checks++; if (c_outst_bad !== 0) begin errors++; $display("FAIL linear outstanding: got %0d want 0", c_outst_bad); end
  endtask

  task automatic test_wrap;
    int bad;
    @(negedge clk_50mhz);
    start_frame(8'hF0);
    collect(100, 0, -1, HDR, BUDGET);
    bad = order_bad(8'hF0);
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL wrap count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap order: got %0d mismatches want 0", bad); end
    checks++; if (addrs.size() !== 256) begin errors++; $display("FAIL wrap reads: got %0d want 256", addrs.size()); end
    checks++; if (addrs[0] !== 8'hF0) begin errors++; $display("FAIL wrap addr0: got %h want f0", addrs[0]); end
    checks++; if (addrs[15] !== 8'hFF || addrs[16] !== 8'h00) begin errors++; $display("FAIL wrap addr15_16: got %h %h want ff 00", addrs[15], addrs[16]); end
  endtask

  task automatic test_stall;
    int reads = 0;
    int bad;
    @(negedge clk_50mhz);
    start_frame(8'h40);
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'b0;
      #1;
      if (mem_re === 1'b1) reads++;
      @(negedge clk_50mhz);
    end
    #1;
    checks++; if (reads !== 2 - HDR) begin errors++; $display("FAIL stall reads: got %0d want %0d", reads, 2 - HDR); end
    checks++; if (out_valid !== 1'b1 || out_data !== exp_byte(8'h40, 0)) begin errors++; $display("FAIL stall head: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_byte(8'h40, 0)); end
    collect(100, 0, -1, HDR + reads, BUDGET);
    bad = order_bad(8'h40);
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL stall count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall order: got %0d mismatches want 0", bad); end
  endtask

  task automatic test_backpressure;
    int bad;
    @(negedge clk_50mhz);
    start_frame(8'h10);
    collect(30, 0, -1, HDR, BUDGET);
    bad = order_bad(8'h10);
    checks++; if (c_timeout !== 1'b0) begin errors++; $display("FAIL bp timeout: got %0d want 0", c_timeout); end
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL bp count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp order: got %0d mismatches want 0", bad); end
    checks++; if (c_stable_bad !== 0) begin errors++; $display("FAIL bp stable: got %0d violations want 0", c_stable_bad); end
    checks++; if (c_outst_bad !== 0) begin errors++; $display("FAIL bp outstanding: got %0d violations want 0", c_outst_bad); end
  endtask

  task automatic test_abort;
    int bad;
    int stray = 0;
    @(negedge clk_50mhz);
    start_frame(8'h20);
    collect(100, 100, -1, HDR, BUDGET);
    checks++; if (got.size() !== 100) begin errors++; $display("FAIL abort pre_count: got %0d want 100", got.size()); end
    @(negedge clk_50mhz);
    out_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk_50mhz);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort done: got %b want 0", done); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50mhz);
      out_ready = 1'b1;
      #1;
      if (out_valid !== 1'b0 || mem_re !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort stray: got %0d active cycles want 0", stray); end
    @(negedge clk_50mhz);
    start_frame(8'h80);
    collect(100, 0, -1, HDR, BUDGET);
    bad = order_bad(8'h80);
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL abort new_count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort new_order: got %0d mismatches want 0", bad); end
  endtask

  task automatic test_retrigger;
    int bad;
    @(negedge clk_50mhz);
    start_frame(8'h00);
    collect(100, 0, 50, HDR, BUDGET);
    bad = order_bad(8'h00);
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL retrig count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL retrig order: got %0d mismatches want 0", bad); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL retrig done: got %b want 1", done); end
    start_frame(8'h33);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL retrig restart: got done=%b busy=%b want 0 1", done, busy); end
    collect(100, 0, -1, HDR, BUDGET);
    bad = order_bad(8'h33);
    checks++; if (got.size() !== FRAME || bad !== 0) begin errors++; $display("FAIL retrig second: got %0d bytes %0d mismatches want %0d 0", got.size(), bad, FRAME); end
  endtask

  task automatic test_top_start;
    @(negedge clk_50mhz);
    start_frame(8'hFF);
    collect(100, 0, -1, HDR, BUDGET);
    checks++; if (got.size() !== FRAME) begin errors++; $display("FAIL top count: got %0d want %0d", got.size(), FRAME); end
    checks++; if (got[HDR] !== 8'hFF || got[HDR + 1] !== 8'h00) begin errors++; $display("FAIL top first: got %h %h want ff 00", got[HDR], got[HDR + 1]); end
    checks++; if (got[FRAME - 1] !== 8'hFE) begin errors++; $display("FAIL top last: got %h want fe", got[FRAME - 1]); end
    checks++; if (addrs[0] !== 8'hFF || addrs[1] !== 8'h00) begin errors++; $display("FAIL top addr: got %h %h want ff 00", addrs[0], addrs[1]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    mem_data = 8'h00;
    test_reset();
    test_linear();
    test_wrap();
    test_stall();
    test_backpressure();
    test_abort();
    test_retrigger();
    test_top_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
